// File: rtl/udp_pkg.sv
// Shared widths, FSM encodings and helpers for the UDP receive port dispatcher.
package udp_pkg;

    localparam int UDP_PORT_W = 16;
    localparam int UDP_LEN_W  = 16;
    localparam int BYTE_CNT_W = 17;
    localparam int KEEP_MAX   = 64;
    localparam int POP_W      = 7;
    localparam int CH_IDX_W   = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MATCH = 2'd1;
    localparam logic [1:0] ST_FWD   = 2'd2;
    localparam logic [1:0] ST_DROP  = 2'd3;

    // Callers zero-extend their keep vector to KEEP_MAX bits.
    function automatic logic [POP_W-1:0] popcount_keep(input logic [KEEP_MAX-1:0] keep);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            n = n + POP_W'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/udp_port_match.sv
// Combinational port matcher: picks the lowest enabled channel whose
// configured port equals the packet's destination port.
module udp_port_match
    import udp_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH*UDP_PORT_W-1:0] i_cfg_port,
    input  logic [NUM_CH-1:0]            i_cfg_en,
    input  logic [UDP_PORT_W-1:0]        i_port,
    output logic                         o_hit,
    output logic [CH_IDX_W-1:0]          o_idx
);

    logic [NUM_CH-1:0] w_eq;

    always_comb begin
        w_eq = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_eq[i] = i_cfg_en[i] && (i_cfg_port[i*UDP_PORT_W +: UDP_PORT_W] == i_port);
        end
    end

    // Scan from the top so the lowest matching index is written last.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_eq[i]) begin
                o_hit = 1'b1;
                o_idx = CH_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/udp_rx_port_dispatch.sv
// Steers UDP payloads to one of NUM_CH consumers by destination port, checks
// payload length against the header and keeps drop / length-error statistics.
//
//   state | meaning
//   IDLE  | waiting for a header descriptor
//   MATCH | one cycle: compare latched port against config
//   FWD   | pass payload through to the selected channel
//   DROP  | consume and discard payload of an unmatched packet
module udp_rx_port_dispatch
    import udp_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_hdr_tvalid,
    output logic                         s_hdr_tready,
    input  logic [UDP_PORT_W-1:0]        s_hdr_dst_port,
    input  logic [UDP_LEN_W-1:0]         s_hdr_len,
    input  logic [DATA_W-1:0]            s_axis_tdata,
    input  logic [DATA_W/8-1:0]          s_axis_tkeep,
    input  logic                         s_axis_tlast,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [NUM_CH*UDP_PORT_W-1:0] cfg_port,
    input  logic [NUM_CH-1:0]            cfg_en,
    output logic [DATA_W-1:0]            m_axis_tdata,
    output logic [DATA_W/8-1:0]          m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic [NUM_CH-1:0]            m_axis_tvalid,
    input  logic [NUM_CH-1:0]            m_axis_tready,
    output logic [CH_IDX_W-1:0]          active_ch,
    output logic                         busy,
    output logic                         len_err,
    output logic [CNT_W-1:0]             drop_cnt,
    output logic [CNT_W-1:0]             len_err_cnt
);

    localparam int KEEP_W = DATA_W / 8;

    logic [1:0]            r_state;
    logic [UDP_PORT_W-1:0] r_dst_port;
    logic [UDP_LEN_W-1:0]  r_len;
    logic [BYTE_CNT_W-1:0] r_byte_cnt;
    logic [CH_IDX_W-1:0]   r_active_ch;
    logic                  r_len_err;
    logic [CNT_W-1:0]      r_drop_cnt;
    logic [CNT_W-1:0]      r_len_err_cnt;

    logic                  w_hit;
    logic [CH_IDX_W-1:0]   w_idx;
    logic                  w_ch_ready;
    logic                  w_beat_fire;
    logic [KEEP_MAX-1:0]   w_keep_ext;
    logic [POP_W-1:0]      w_pop;
    logic [BYTE_CNT_W:0]   w_sum;
    logic [BYTE_CNT_W-1:0] w_byte_next;
    logic                  w_len_bad;

    udp_port_match #(
        .NUM_CH (NUM_CH)
    ) u_match (
        .i_cfg_port (cfg_port),
        .i_cfg_en   (cfg_en),
        .i_port     (r_dst_port),
        .o_hit      (w_hit),
        .o_idx      (w_idx)
    );

    always_comb begin
        w_ch_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_active_ch == CH_IDX_W'(i)) begin
                w_ch_ready = m_axis_tready[i];
            end
        end
    end

    always_comb begin
        s_hdr_tready  = (r_state == ST_IDLE);
        s_axis_tready = 1'b0;
        case (r_state)
            ST_FWD:  s_axis_tready = w_ch_ready;
            ST_DROP: s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b0;
        endcase
    end

    // Valid is steered combinationally so forwarding adds no latency.
    always_comb begin
        m_axis_tvalid = '0;
        if (r_state == ST_FWD) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_axis_tvalid[i] = s_axis_tvalid && (r_active_ch == CH_IDX_W'(i));
            end
        end
    end

    always_comb begin
        w_keep_ext = '0;
        w_keep_ext[KEEP_W-1:0] = s_axis_tkeep;
    end

    assign w_pop       = popcount_keep(w_keep_ext);
    assign w_beat_fire = s_axis_tvalid && s_axis_tready;
    assign w_sum       = {1'b0, r_byte_cnt} + (BYTE_CNT_W+1)'(w_pop);
    // Oversized streams pin the byte count at its maximum instead of wrapping.
    assign w_byte_next = w_sum[BYTE_CNT_W] ? '1 : w_sum[BYTE_CNT_W-1:0];
    assign w_len_bad   = (w_sum != (BYTE_CNT_W+1)'(r_len));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_dst_port    <= '0;
            r_len         <= '0;
            r_byte_cnt    <= '0;
            r_active_ch   <= '0;
            r_len_err     <= 1'b0;
            r_drop_cnt    <= '0;
            r_len_err_cnt <= '0;
        end else begin
            r_len_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (s_hdr_tvalid) begin
                        r_dst_port <= s_hdr_dst_port;
                        r_len      <= s_hdr_len;
                        r_byte_cnt <= '0;
                        r_state    <= ST_MATCH;
                    end
                end
                ST_MATCH: begin
                    if (r_len == '0) begin
                        r_state <= ST_IDLE;
                    end else if (w_hit) begin
                        r_active_ch <= w_idx;
                        r_state     <= ST_FWD;
                    end else begin
                        if (r_drop_cnt != '1) begin
                            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                        end
                        r_state <= ST_DROP;
                    end
                end
                ST_FWD: begin
                    if (w_beat_fire) begin
                        r_byte_cnt <= w_byte_next;
                        if (s_axis_tlast) begin
                            if (w_len_bad) begin
                                r_len_err <= 1'b1;
                                if (r_len_err_cnt != '1) begin
                                    r_len_err_cnt <= r_len_err_cnt + CNT_W'(1);
                                end
                            end
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (w_beat_fire && s_axis_tlast) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tkeep = s_axis_tkeep;
    assign m_axis_tlast = s_axis_tlast;
    assign active_ch    = r_active_ch;
    assign busy         = (r_state != ST_IDLE);
    assign len_err      = r_len_err;
    assign drop_cnt     = r_drop_cnt;
    assign len_err_cnt  = r_len_err_cnt;

endmodule
